// File: rtl/i2s_sample_feeder_if.sv
// Bus-side and transmitter-side signal bundle for i2s_sample_feeder.
//   slave modport  : the feeder (consumes Enable/WrData/WrEn/SyncCLK/FlagClr,
//                    drives FIFO status, SampleOut and error flags)
//   master modport : the environment driving writes and frame strobes
interface i2s_sample_feeder_if #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  Enable;
  logic [DATA_WIDTH-1:0] WrData;
  logic                  WrEn;
  logic                  Full;
  logic                  Empty;
  logic [DEPTH_LOG2:0]   Level;
  logic                  SyncCLK;
  logic [DATA_WIDTH-1:0] SampleOut;
  logic                  Underrun;
  logic                  Overflow;
  logic                  FlagClr;
  logic [15:0]           UnderrunCount;

  modport slave (
    input  Enable, WrData, WrEn, SyncCLK, FlagClr,
    output Full, Empty, Level, SampleOut, Underrun, Overflow, UnderrunCount
  );

  modport master (
    output Enable, WrData, WrEn, SyncCLK, FlagClr,
    input  Full, Empty, Level, SampleOut, Underrun, Overflow, UnderrunCount
  );
endinterface

// File: rtl/i2s_sample_feeder.sv
// Sample FIFO feeding an I2S transmitter: one word popped per SyncCLK frame
// strobe (resynchronised into MasterCLK), silence plus sticky underrun flag
// when starved, sticky overflow flag when a write hits a full FIFO.
// Ports:
//   MasterCLK : system clock, all state on rising edge
//   Reset     : asynchronous active-high reset
//   bus       : i2s_sample_feeder_if.slave (write side, status, SampleOut, flags)
module i2s_sample_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  MasterCLK,
  input  logic                  Reset,
  i2s_sample_feeder_if.slave    bus
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned AW    = DEPTH_LOG2 + 1;
  localparam int unsigned CW    = 16;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [2:0]            sync_q, sync_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         level_q, level_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic [DATA_WIDTH-1:0] sample_q, sample_d;
  logic                  underrun_q, underrun_d;
  logic                  overflow_q, overflow_d;
  logic [CW-1:0]         urun_cnt_q, urun_cnt_d;

  logic pop_evt;
  logic pop_rd;
  logic pop_urun;
  logic wr_acc;
  logic wr_drop;

  // Next-state: synchroniser shift, pop/write decode, pointers, flags
  always_comb begin
    sync_d     = {sync_q[1:0], bus.SyncCLK};
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sample_d   = sample_q;
    underrun_d = underrun_q;
    overflow_d = overflow_q;
    urun_cnt_d = urun_cnt_q;

    // s2 & ~s3: one-cycle strobe per SyncCLK rising edge
    pop_evt  = sync_q[1] & ~sync_q[2];
    pop_rd   = pop_evt & bus.Enable & ~empty_q;
    pop_urun = pop_evt & bus.Enable & empty_q;
    // A write into a full FIFO still fits when the same cycle pops a word
    wr_acc   = bus.WrEn & (~full_q | pop_rd);
    wr_drop  = bus.WrEn & ~wr_acc;

    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop_rd) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    if (pop_evt) begin
      sample_d = pop_rd ? mem_q[rd_ptr_q[DEPTH_LOG2-1:0]] : '0;
    end

    if (bus.FlagClr) begin
      underrun_d = 1'b0;
      overflow_d = 1'b0;
    end
    // Set events take priority over a same-cycle clear
    if (pop_urun) begin
      underrun_d = 1'b1;
      if (urun_cnt_q != {CW{1'b1}}) begin
        urun_cnt_d = urun_cnt_q + CW'(1);
      end
    end
    if (wr_drop) begin
      overflow_d = 1'b1;
    end

    level_d = wr_ptr_d - rd_ptr_d;
    full_d  = (level_d == AW'(DEPTH));
    empty_d = (level_d == '0);
  end

  // State registers
  always_ff @(posedge MasterCLK or posedge Reset) begin
    if (Reset) begin
      sync_q     <= 3'b111;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      sample_q   <= '0;
      underrun_q <= 1'b0;
      overflow_q <= 1'b0;
      urun_cnt_q <= '0;
    end else begin
      sync_q     <= sync_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      sample_q   <= sample_d;
      underrun_q <= underrun_d;
      overflow_q <= overflow_d;
      urun_cnt_q <= urun_cnt_d;
    end
  end

  // Storage array, no reset needed: contents are only read once written
  always_ff @(posedge MasterCLK) begin
    if (wr_acc) begin
      mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= bus.WrData;
    end
  end

  assign bus.Full          = full_q;
  assign bus.Empty         = empty_q;
  assign bus.Level         = level_q;
  assign bus.SampleOut     = sample_q;
  assign bus.Underrun      = underrun_q;
  assign bus.Overflow      = overflow_q;
  assign bus.UnderrunCount = urun_cnt_q;

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Scoreboard bench for i2s_sample_feeder: each frame strobe pushes the
// expected SampleOut word; a monitor checks it lands exactly on the 3rd edge.
module tb_i2s_sample_feeder;

  logic clk;
  logic rst;

  int n_cmp;
  int n_err;

  logic [31:0] exp_q [$];
  event        pop_ev;
  logic [31:0] fill_words [16];

  i2s_sample_feeder_if #(.DEPTH_LOG2(4), .DATA_WIDTH(32)) bus ();

  i2s_sample_feeder #(.DEPTH_LOG2(4), .DATA_WIDTH(32)) dut (
    .MasterCLK (clk),
    .Reset     (rst),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame strobe; optional write lined up with the internal pop strobe
  task automatic sync_pulse(input logic [31:0] exp, input bit do_wr, input logic [31:0] wd);
    exp_q.push_back(exp);
    @(negedge clk);
    bus.SyncCLK = 1'b1;
    -> pop_ev;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (do_wr) begin
      bus.WrEn   = 1'b1;
      bus.WrData = wd;
    end
    @(negedge clk);
    bus.WrEn = 1'b0;
    repeat (2) @(negedge clk);
    bus.SyncCLK = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    bus.WrEn   = 1'b1;
    bus.WrData = d;
    @(negedge clk);
    bus.WrEn   = 1'b0;
  endtask

  task automatic flag_clr();
    @(negedge clk);
    bus.FlagClr = 1'b1;
    @(negedge clk);
    bus.FlagClr = 1'b0;
  endtask

  // Monitor: old value still held after edge 2, new word after edge 3
  initial begin : monitor
    logic [31:0] last;
    logic [31:0] exp;
    last = 32'h0;
    forever begin
      @(pop_ev);
      repeat (2) @(posedge clk);
      #1;
      check("sample_hold_before_3rd_edge", bus.SampleOut, last);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sample_pop: no expected word queued, got %h", bus.SampleOut);
      end else begin
        exp = exp_q.pop_front();
        check("sample_pop", bus.SampleOut, exp);
        last = exp;
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    n_cmp = 0;
    n_err = 0;
    for (int i = 0; i < 16; i++) fill_words[i] = 32'hA5000000 + 32'(i * 32'h00010101);

    bus.Enable  = 1'b1;
    bus.WrData  = '0;
    bus.WrEn    = 1'b0;
    bus.SyncCLK = 1'b1;
    bus.FlagClr = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Reset with SyncCLK high: no pop
    check("rst_sample", bus.SampleOut, 32'h0);
    check("rst_empty", 32'(bus.Empty), 32'd1);
    check("rst_full", 32'(bus.Full), 32'd0);
    check("rst_level", 32'(bus.Level), 32'd0);
    check("rst_underrun", 32'(bus.Underrun), 32'd0);
    check("rst_overflow", 32'(bus.Overflow), 32'd0);
    check("rst_urun_cnt", 32'(bus.UnderrunCount), 32'd0);
    bus.SyncCLK = 1'b0;
    repeat (4) @(negedge clk);

    // Basic two-word play-out
    wr(32'h11112222);
    wr(32'h33334444);
    check("two_level", 32'(bus.Level), 32'd2);
    sync_pulse(32'h11112222, 1'b0, '0);
    check("two_level_after1", 32'(bus.Level), 32'd1);
    check("two_empty_after1", 32'(bus.Empty), 32'd0);
    sync_pulse(32'h33334444, 1'b0, '0);
    check("two_empty_after2", 32'(bus.Empty), 32'd1);
    check("two_level_after2", 32'(bus.Level), 32'd0);

    // Fill, overflow, clear
    for (int i = 0; i < 16; i++) wr(fill_words[i]);
    check("fill_full", 32'(bus.Full), 32'd1);
    check("fill_level", 32'(bus.Level), 32'd16);
    check("fill_overflow0", 32'(bus.Overflow), 32'd0);
    wr(32'hDEADBEEF);
    check("ovf_full", 32'(bus.Full), 32'd1);
    check("ovf_flag", 32'(bus.Overflow), 32'd1);
    check("ovf_level", 32'(bus.Level), 32'd16);
    flag_clr();
    check("ovf_clr", 32'(bus.Overflow), 32'd0);

    // Full FIFO, write coincident with pop
    sync_pulse(fill_words[0], 1'b1, 32'hCAFE0001);
    check("fullco_overflow", 32'(bus.Overflow), 32'd0);
    check("fullco_level", 32'(bus.Level), 32'd16);
    check("fullco_full", 32'(bus.Full), 32'd1);

    for (int i = 1; i < 16; i++) sync_pulse(fill_words[i], 1'b0, '0);
    sync_pulse(32'hCAFE0001, 1'b0, '0);
    check("drain_empty", 32'(bus.Empty), 32'd1);
    check("drain_underrun", 32'(bus.Underrun), 32'd0);

    // Underruns on empty FIFO
    for (int i = 0; i < 3; i++) sync_pulse(32'h0, 1'b0, '0);
    check("urun_flag", 32'(bus.Underrun), 32'd1);
    check("urun_cnt3", 32'(bus.UnderrunCount), 32'd3);
    flag_clr();
    check("urun_clr", 32'(bus.Underrun), 32'd0);
    check("urun_cnt_kept", 32'(bus.UnderrunCount), 32'd3);

    // Empty FIFO, write coincident with pop
    sync_pulse(32'h0, 1'b1, 32'h5555AAAA);
    check("emptyco_underrun", 32'(bus.Underrun), 32'd1);
    check("emptyco_level", 32'(bus.Level), 32'd1);
    check("emptyco_empty", 32'(bus.Empty), 32'd0);
    check("emptyco_cnt", 32'(bus.UnderrunCount), 32'd4);
    sync_pulse(32'h5555AAAA, 1'b0, '0);
    check("emptyco_drained", 32'(bus.Level), 32'd0);
    flag_clr();

    // Enable low: silence, no consumption, no underrun
    for (int i = 0; i < 5; i++) wr(32'hB0B00000 + 32'(i));
    check("dis_level5", 32'(bus.Level), 32'd5);
    @(negedge clk);
    bus.Enable = 1'b0;
    for (int i = 0; i < 4; i++) sync_pulse(32'h0, 1'b0, '0);
    check("dis_level_kept", 32'(bus.Level), 32'd5);
    check("dis_underrun", 32'(bus.Underrun), 32'd0);
    check("dis_cnt", 32'(bus.UnderrunCount), 32'd4);
    @(negedge clk);
    bus.Enable = 1'b1;
    sync_pulse(32'hB0B00000, 1'b0, '0);
    check("en_level4", 32'(bus.Level), 32'd4);

    // Let the monitor drain its queue, bounded
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
